// File: rtl/sched_pkg.sv
// Shared types and constants for the in-order wide issue scheduler.
package sched_pkg;

    localparam int unsigned SCHED_NREGS = 32;
    localparam int unsigned REG_IDX_W   = $clog2(SCHED_NREGS);
    localparam int unsigned NUNITS      = 4;
    localparam int unsigned OPC_W       = 8;
    localparam int unsigned ROB_OFF_W   = 2;
    localparam int unsigned SLOT_W      = 2;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_MEM = 2'd2,
        UNIT_BR  = 2'd3
    } unit_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] idx;
    } reg_sel_t;

    typedef struct packed {
        logic             valid;
        unit_e            unit;
        logic [OPC_W-1:0] opc;
        reg_sel_t         rd;
        reg_sel_t         rs1;
        reg_sel_t         rs2;
    } decoded_instr_t;

    typedef struct packed {
        decoded_instr_t       instr;
        logic [ROB_OFF_W-1:0] rob_off;
        logic [SLOT_W-1:0]    slot;
    } issued_instr_t;

    typedef reg_sel_t [2:0] reg_trio_t;

    // Default two-port map: port0 ALU/MUL/BR, port1 ALU/MEM (bit u = unit u).
    localparam logic [1:0][NUNITS-1:0] PORT_CAPS_DEF = {4'b0101, 4'b1011};

    // Register operands of an instruction in lookup order: rs1, rs2, rd.
    function automatic reg_trio_t instr_regs(input decoded_instr_t ins);
        return {ins.rd, ins.rs2, ins.rs1};
    endfunction

endpackage

// File: rtl/sched_scoreboard.sv
// Integer register busy bits with writeback clear, issue set and
// same-cycle writeback bypass on every lookup.
module sched_scoreboard
    import sched_pkg::*;
#(
    parameter int unsigned NREGS    = SCHED_NREGS,
    parameter int unsigned W        = 2,
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned NLOOK    = 3 * W
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_flush,
    input  logic [WB_PORTS-1:0]                i_wb_valid,
    input  logic [WB_PORTS-1:0][REG_IDX_W-1:0] i_wb_idx,
    input  logic [W-1:0]                       i_set_valid,
    input  logic [W-1:0][REG_IDX_W-1:0]        i_set_idx,
    input  logic [NLOOK-1:0][REG_IDX_W-1:0]    i_look_idx,
    output logic [NLOOK-1:0]                   o_look_rdy_c
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Sets are applied after clears so an issuing writer wins over a writeback.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < WB_PORTS; w++) begin
            if (i_wb_valid[w]) busy_d[i_wb_idx[w]] = 1'b0;
        end
        for (int k = 0; k < W; k++) begin
            if (i_set_valid[k] && i_set_idx[k] != '0) busy_d[i_set_idx[k]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) busy_q <= '0;
        else                  busy_q <= busy_d;
    end

    always_comb begin
        o_look_rdy_c = '0;
        for (int l = 0; l < NLOOK; l++) begin
            o_look_rdy_c[l] = !busy_q[i_look_idx[l]];
            for (int w = 0; w < WB_PORTS; w++) begin
                if (i_wb_valid[w] && i_wb_idx[w] == i_look_idx[l]) o_look_rdy_c[l] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_sched_wide.sv
// In-order issue stage: holds one decoded bundle and issues its oldest ready
// prefix onto typed ports, with scoreboard tracking and decode backpressure.
module issue_sched_wide
    import sched_pkg::*;
#(
    parameter int unsigned W        = 2,
    parameter int unsigned P        = 2,
    parameter int unsigned NREGS    = SCHED_NREGS,
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned ROBC_W   = 4,
    parameter logic [P-1:0][NUNITS-1:0] PORT_CAPS = PORT_CAPS_DEF,
    localparam int unsigned CNT_W   = $clog2(W) + 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_flush,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  decoded_instr_t [W-1:0]             i_instrs,
    input  logic [P-1:0]                       i_port_rdy,
    input  logic [ROBC_W-1:0]                  i_rob_free,
    input  logic [WB_PORTS-1:0]                i_wb_valid,
    input  logic [WB_PORTS-1:0][REG_IDX_W-1:0] i_wb_idx,
    output logic [P-1:0]                       o_iss_valid,
    output issued_instr_t [P-1:0]              o_iss_instr,
    output logic [CNT_W-1:0]                   o_iss_count
);

    localparam int unsigned PORT_W = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned NLOOK  = 3 * W;

    decoded_instr_t [W-1:0]          buf_q;
    logic [W-1:0]                    rem_q;
    logic [W-1:0]                    slot_rdy;
    logic [W-1:0]                    grant;
    logic [W-1:0]                    sb_set;
    logic [W-1:0][REG_IDX_W-1:0]     sb_set_idx;
    logic [NLOOK-1:0][REG_IDX_W-1:0] look_idx;
    logic [NLOOK-1:0]                look_rdy;
    reg_trio_t                       regs;
    logic [P-1:0]                    port_used;
    logic [PORT_W-1:0]               pick;
    logic                            found;
    logic                            stall;
    int unsigned                     n_grant;
    logic [P-1:0]                    iss_valid_d;
    issued_instr_t [P-1:0]           iss_instr_d;

    sched_scoreboard #(
        .NREGS    (NREGS),
        .W        (W),
        .WB_PORTS (WB_PORTS),
        .NLOOK    (NLOOK)
    ) u_sb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_wb_valid   (i_wb_valid),
        .i_wb_idx     (i_wb_idx),
        .i_set_valid  (sb_set),
        .i_set_idx    (sb_set_idx),
        .i_look_idx   (look_idx),
        .o_look_rdy_c (look_rdy)
    );

    always_comb begin
        look_idx = '0;
        for (int k = 0; k < W; k++) begin
            look_idx[3*k]     = buf_q[k].rs1.idx;
            look_idx[3*k + 1] = buf_q[k].rs2.idx;
            look_idx[3*k + 2] = buf_q[k].rd.idx;
        end
    end

    // Operand readiness plus RAW/WAW against older still-remaining writers.
    always_comb begin
        slot_rdy = '0;
        regs     = '0;
        for (int k = 0; k < W; k++) begin
            slot_rdy[k] = rem_q[k];
            regs        = instr_regs(buf_q[k]);
            for (int s = 0; s < 3; s++) begin
                if (regs[s].valid && !look_rdy[3*k + s]) slot_rdy[k] = 1'b0;
                for (int j = 0; j < k; j++) begin
                    if (rem_q[j] && buf_q[j].rd.valid && buf_q[j].rd.idx != '0 &&
                        regs[s].valid && regs[s].idx == buf_q[j].rd.idx)
                        slot_rdy[k] = 1'b0;
                end
            end
        end
    end

    // Strict in-order grant with greedy lowest-port allocation and ROB limit.
    always_comb begin
        grant       = '0;
        port_used   = '0;
        pick        = '0;
        found       = 1'b0;
        stall       = 1'b0;
        n_grant     = 0;
        iss_valid_d = '0;
        iss_instr_d = '0;
        for (int k = 0; k < W; k++) begin
            if (rem_q[k] && !stall) begin
                found = 1'b0;
                pick  = '0;
                for (int p = 0; p < P; p++) begin
                    if (!found && !port_used[p] && i_port_rdy[p] && PORT_CAPS[p][buf_q[k].unit]) begin
                        found = 1'b1;
                        pick  = PORT_W'(p);
                    end
                end
                if (slot_rdy[k] && found && n_grant < 32'(i_rob_free)) begin
                    grant[k]          = 1'b1;
                    port_used[pick]   = 1'b1;
                    iss_valid_d[pick] = 1'b1;
                    iss_instr_d[pick] = '{instr:   buf_q[k],
                                          rob_off: ROB_OFF_W'(n_grant),
                                          slot:    SLOT_W'(k)};
                    n_grant           = n_grant + 1;
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sb_set     = '0;
        sb_set_idx = '0;
        for (int k = 0; k < W; k++) begin
            sb_set[k]     = grant[k] && buf_q[k].rd.valid;
            sb_set_idx[k] = buf_q[k].rd.idx;
        end
    end

    assign o_ready = !i_rst && !i_flush && ((rem_q & ~grant) == '0);

    // Holding buffer; invalid slots never become remaining.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            buf_q <= '0;
            rem_q <= '0;
        end else if (i_valid && o_ready) begin
            buf_q <= i_instrs;
            for (int k = 0; k < W; k++) rem_q[k] <= i_instrs[k].valid;
        end else begin
            rem_q <= rem_q & ~grant;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_iss_valid <= '0;
            o_iss_instr <= '0;
            o_iss_count <= '0;
        end else begin
            o_iss_valid <= iss_valid_d;
            o_iss_instr <= iss_instr_d;
            o_iss_count <= CNT_W'(n_grant);
        end
    end

endmodule

// File: tb/tb_issue_sched_wide.sv
// Randomised and directed bench for issue_sched_wide against a behavioural
// model of bundle issue, port typing and register readiness.
module tb_issue_sched_wide;
    import sched_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned P  = 2;
    localparam int unsigned WB = 2;

    logic                        clk = 1'b0;
    logic                        rst, flush, valid, ready;
    decoded_instr_t [W-1:0]      instrs;
    logic [P-1:0]                port_rdy;
    logic [3:0]                  rob_free;
    logic [WB-1:0]               wb_valid;
    logic [WB-1:0][REG_IDX_W-1:0] wb_idx;
    logic [P-1:0]                iss_valid;
    issued_instr_t [P-1:0]       iss_instr;
    logic [1:0]                  iss_count;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state
    decoded_instr_t  m_buf [W];
    logic [W-1:0]    m_rem  = '0;
    logic [31:0]     m_busy = '0;
    logic [W-1:0]    m_grant;
    logic            exp_ready;
    logic [P-1:0]    exp_valid;
    issued_instr_t   exp_instr [P];
    int              exp_cnt;

    always #5 clk = ~clk;

    issue_sched_wide #(.W(W), .P(P), .NREGS(32), .WB_PORTS(WB), .ROBC_W(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_instrs    (instrs),
        .i_port_rdy  (port_rdy),
        .i_rob_free  (rob_free),
        .i_wb_valid  (wb_valid),
        .i_wb_idx    (wb_idx),
        .o_iss_valid (iss_valid),
        .o_iss_instr (iss_instr),
        .o_iss_count (iss_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Ports able to execute a unit: ALU anywhere, MUL/BR port0, MEM port1.
    function automatic logic [P-1:0] caps_of(input unit_e u);
        case (u)
            UNIT_ALU: return 2'b11;
            UNIT_MEM: return 2'b10;
            default:  return 2'b01;
        endcase
    endfunction

    function automatic logic reg_free(input reg_sel_t r);
        if (!r.valid || !m_busy[r.idx]) return 1'b1;
        for (int w = 0; w < WB; w++) if (wb_valid[w] && wb_idx[w] == r.idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic conflicts(input reg_sel_t r, input int k);
        if (!r.valid) return 1'b0;
        for (int j = 0; j < k; j++)
            if (m_rem[j] && m_buf[j].rd.valid && m_buf[j].rd.idx != 0 && m_buf[j].rd.idx == r.idx)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic slot_ok(input int k);
        reg_sel_t r [3];
        r[0] = m_buf[k].rs1; r[1] = m_buf[k].rs2; r[2] = m_buf[k].rd;
        for (int s = 0; s < 3; s++) if (!reg_free(r[s]) || conflicts(r[s], k)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_eval();
        logic [P-1:0] free, cap;
        int n, pp;
        m_grant   = '0;
        exp_valid = '0;
        for (int p = 0; p < P; p++) exp_instr[p] = '0;
        free = port_rdy;
        n    = 0;
        for (int k = 0; k < W; k++) begin
            if (!m_rem[k]) continue;
            if (!slot_ok(k)) break;
            cap = caps_of(m_buf[k].unit) & free;
            pp  = -1;
            for (int p = P - 1; p >= 0; p--) if (cap[p]) pp = p;
            if (pp < 0 || n >= int'(rob_free)) break;
            m_grant[k]    = 1'b1;
            free[pp]      = 1'b0;
            exp_valid[pp] = 1'b1;
            exp_instr[pp] = '{instr: m_buf[k], rob_off: 2'(n), slot: 2'(k)};
            n++;
        end
        exp_cnt   = n;
        exp_ready = !rst && !flush && ((m_rem & ~m_grant) == '0);
    endtask

    task automatic model_commit();
        if (rst || flush) begin
            m_rem     = '0;
            m_busy    = '0;
            exp_valid = '0;
            exp_cnt   = 0;
            for (int p = 0; p < P; p++) exp_instr[p] = '0;
        end else begin
            for (int w = 0; w < WB; w++) if (wb_valid[w]) m_busy[wb_idx[w]] = 1'b0;
            for (int k = 0; k < W; k++)
                if (m_grant[k] && m_buf[k].rd.valid && m_buf[k].rd.idx != 0) m_busy[m_buf[k].rd.idx] = 1'b1;
            if (valid && exp_ready) begin
                for (int k = 0; k < W; k++) begin
                    m_buf[k] = instrs[k];
                    m_rem[k] = instrs[k].valid;
                end
            end else begin
                m_rem = m_rem & ~m_grant;
            end
        end
    endtask

    // One clock: evaluate the model, check o_ready, clock, check issue outputs.
    task automatic cycle();
        logic clr;
        #2;
        model_eval();
        clr = rst || flush;
        if (!clr) chk("o_ready", 64'(ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        model_commit();
        chk("iss_valid", 64'(iss_valid), 64'(exp_valid));
        chk("iss_count", 64'(iss_count), 64'(exp_cnt));
        for (int p = 0; p < P; p++)
            if (exp_valid[p] || clr) chk("iss_instr", 64'(iss_instr[p]), 64'(exp_instr[p]));
    endtask

    task automatic chk_ready(input string tag, input logic e);
        #1;
        chk(tag, 64'(ready), 64'(e));
    endtask

    function automatic decoded_instr_t ins(input unit_e u, input int rd, input int rs1, input int rs2);
        decoded_instr_t d;
        d           = '0;
        d.valid     = 1'b1;
        d.unit      = u;
        d.opc       = 8'($urandom);
        d.rd.valid  = (rd >= 0);
        d.rd.idx    = (rd >= 0) ? 5'(rd) : 5'd0;
        d.rs1.valid = (rs1 >= 0);
        d.rs1.idx   = (rs1 >= 0) ? 5'(rs1) : 5'd0;
        d.rs2.valid = (rs2 >= 0);
        d.rs2.idx   = (rs2 >= 0) ? 5'(rs2) : 5'd0;
        return d;
    endfunction

    function automatic decoded_instr_t rnd_ins();
        decoded_instr_t d;
        d           = '0;
        d.valid     = ($urandom_range(0, 9) != 0);
        d.unit      = unit_e'($urandom_range(0, 3));
        d.opc       = 8'($urandom);
        d.rd.valid  = ($urandom_range(0, 3) != 0);
        d.rd.idx    = 5'($urandom_range(0, 7));
        d.rs1.valid = ($urandom_range(0, 2) != 0);
        d.rs1.idx   = 5'($urandom_range(0, 7));
        d.rs2.valid = ($urandom_range(0, 2) != 0);
        d.rs2.idx   = 5'($urandom_range(0, 7));
        return d;
    endfunction

    task automatic wb1(input int r0, input int r1);
        wb_valid  = 2'b11;
        wb_idx[0] = 5'(r0);
        wb_idx[1] = 5'(r1);
        cycle();
        wb_valid  = '0;
    endtask

    task automatic load(input decoded_instr_t a, input decoded_instr_t b);
        valid     = 1'b1;
        instrs[0] = a;
        instrs[1] = b;
        cycle();
        valid     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; instrs = '0;
        port_rdy = 2'b11; rob_free = 4'd4; wb_valid = '0; wb_idx = '0;
        cycle();
        cycle();
        rst = 1'b0;

        // Two independent ALU ops issue together
        load(ins(UNIT_ALU, 1, 2, 3), ins(UNIT_ALU, 4, 5, 6));
        cycle();
        chk("dual_valid", 64'(iss_valid), 64'(2'b11));
        chk("dual_count", 64'(iss_count), 64'(2));
        wb1(1, 4);

        // RAW inside the bundle, resolved by writeback bypass
        load(ins(UNIT_ALU, 1, 2, 3), ins(UNIT_ALU, 7, 1, 2));
        chk_ready("raw_ready_lo", 1'b0);
        cycle();
        chk("raw_count1", 64'(iss_count), 64'(1));
        wb_valid = 2'b01; wb_idx[0] = 5'd1;
        chk_ready("raw_ready_hi", 1'b1);
        cycle();
        wb_valid = '0;
        chk("raw_slot1", 64'(iss_instr[0].slot), 64'(1));
        wb1(7, 1);

        // Typed ports: MEM to port1, MUL to port0
        load(ins(UNIT_MEM, 10, 2, -1), ins(UNIT_MUL, 11, 3, 4));
        cycle();
        chk("typed_valid", 64'(iss_valid), 64'(2'b11));
        chk("typed_off_mem", 64'(iss_instr[1].rob_off), 64'(0));
        chk("typed_off_mul", 64'(iss_instr[0].rob_off), 64'(1));
        wb1(10, 11);
        load(ins(UNIT_MEM, 10, 2, -1), ins(UNIT_MUL, 11, 3, 4));
        port_rdy = 2'b10;
        cycle();
        chk("mul_busy_valid", 64'(iss_valid), 64'(2'b10));
        port_rdy = 2'b11;
        cycle();
        chk("mul_late_valid", 64'(iss_valid), 64'(2'b01));
        wb1(10, 11);

        // ROB limit of one
        rob_free = 4'd1;
        load(ins(UNIT_ALU, 12, -1, -1), ins(UNIT_ALU, 13, -1, -1));
        cycle();
        chk("rob1_count", 64'(iss_count), 64'(1));
        cycle();
        chk("rob1_next", 64'(iss_count), 64'(1));
        rob_free = 4'd0;
        load(ins(UNIT_ALU, 20, -1, -1), ins(UNIT_ALU, 21, -1, -1));
        cycle();
        chk("rob0_count", 64'(iss_count), 64'(0));
        rob_free = 4'd4;
        cycle();
        wb1(12, 13);
        wb1(20, 21);

        // Oldest stalled on busy x9 blocks the younger independent slot
        load(ins(UNIT_ALU, 9, -1, -1), '0);
        cycle();
        load(ins(UNIT_ALU, 14, 9, -1), ins(UNIT_ALU, 15, 2, 3));
        cycle();
        chk("inorder_stall", 64'(iss_count), 64'(0));
        wb_valid = 2'b11; wb_idx[0] = 5'd9; wb_idx[1] = 5'd9;
        cycle();
        wb_valid = '0;
        chk("inorder_go", 64'(iss_count), 64'(2));
        wb1(14, 15);

        // Flush with a stalled slot pending on x1
        load(ins(UNIT_ALU, 1, -1, -1), ins(UNIT_ALU, 16, 1, -1));
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid", 64'(iss_valid), 64'(0));
        valid = 1'b1; instrs[0] = ins(UNIT_ALU, 17, 1, 1); instrs[1] = '0;
        chk_ready("flush_ready", 1'b1);
        cycle();
        valid = 1'b0;
        cycle();
        chk("flush_x1_ready", 64'(iss_count), 64'(1));

        // All-invalid bundle is consumed with no issue
        load('0, '0);
        chk_ready("empty_ready", 1'b1);
        cycle();
        chk("empty_count", 64'(iss_count), 64'(0));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            valid     = ($urandom_range(0, 9) < 7);
            instrs[0] = rnd_ins();
            instrs[1] = rnd_ins();
            port_rdy  = 2'($urandom_range(0, 3) | ($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00));
            rob_free  = 4'($urandom_range(0, 5));
            wb_valid  = 2'($urandom_range(0, 3));
            wb_idx[0] = 5'($urandom_range(0, 7));
            wb_idx[1] = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
